// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection and EX/MEM, MEM/WB forwarding.
// Stall keeps the instruction in EX and refreshes forwarded operands in place.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_aluop,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic          id_use_imm,
    input  logic          id_imm_sign,
    input  logic          id_lui,
    input  logic          id_use_shamt,
    input  logic [4:0]    id_shamt,
    input  logic          id_reg_write,
    input  logic          exm_reg_write,
    input  logic [AW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          mwb_reg_write,
    input  logic [AW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_result,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_in_a,
    output logic [DW-1:0] alu_in_b,
    output logic [DW-1:0] ex_store_data,
    output logic [AW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_valid
);

    logic          valid_reg;
    logic          reg_write_reg;
    logic [3:0]    op_reg;
    logic [AW-1:0] rd_reg;
    logic [AW-1:0] rs_addr_reg;
    logic [AW-1:0] rt_addr_reg;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] rt_reg;
    logic          a_is_reg_reg;
    logic          b_is_reg_reg;

    // Index 0 is the rs operand, index 1 is the rt operand.
    logic [AW-1:0] src_addr [2];
    logic [1:0]    exm_hit;
    logic [1:0]    mwb_hit;
    logic [1:0]    fwd_hit;
    logic [DW-1:0] fwd_data [2];

    assign src_addr[0] = rs_addr_reg;
    assign src_addr[1] = rt_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign exm_hit[gi]  = exm_reg_write && (exm_rd != '0) && (exm_rd == src_addr[gi]);
            assign mwb_hit[gi]  = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_addr[gi]);
            assign fwd_hit[gi]  = exm_hit[gi] || mwb_hit[gi];
            assign fwd_data[gi] = exm_hit[gi] ? exm_result : mwb_result;
        end
    endgenerate

    logic [DW-1:0] a_fwd;
    logic [DW-1:0] b_fwd;
    logic [DW-1:0] rt_fwd;

    assign a_fwd  = (a_is_reg_reg && fwd_hit[0]) ? fwd_data[0] : a_reg;
    assign b_fwd  = (b_is_reg_reg && fwd_hit[1]) ? fwd_data[1] : b_reg;
    assign rt_fwd = fwd_hit[1] ? fwd_data[1] : rt_reg;

    logic [DW-1:0] imm_ext;
    logic          b_uses_imm;

    assign b_uses_imm = id_use_imm || id_lui;
    assign imm_ext    = id_lui      ? {id_imm16, {(DW-16){1'b0}}} :
                        id_imm_sign ? {{(DW-16){id_imm16[15]}}, id_imm16} :
                                      {{(DW-16){1'b0}}, id_imm16};

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !id_valid)) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
            op_reg        <= 4'b0000;
            rd_reg        <= '0;
            rs_addr_reg   <= '0;
            rt_addr_reg   <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rt_reg        <= '0;
            a_is_reg_reg  <= 1'b0;
            b_is_reg_reg  <= 1'b0;
        end else if (stall) begin
            // Capture forwarded values so they outlive the producer leaving the pipe.
            if (valid_reg) begin
                a_reg  <= a_fwd;
                b_reg  <= b_fwd;
                rt_reg <= rt_fwd;
            end
        end else begin
            valid_reg     <= 1'b1;
            reg_write_reg <= id_reg_write;
            op_reg        <= id_lui ? 4'b0000 : id_aluop;
            rd_reg        <= id_rd_addr;
            rs_addr_reg   <= id_rs_addr;
            rt_addr_reg   <= id_rt_addr;
            a_reg         <= id_use_shamt ? {{(DW-5){1'b0}}, id_shamt} : id_rs_data;
            b_reg         <= b_uses_imm ? imm_ext : id_rt_data;
            rt_reg        <= id_rt_data;
            a_is_reg_reg  <= !id_use_shamt;
            b_is_reg_reg  <= !b_uses_imm;
        end
    end

    assign alu_op        = op_reg;
    assign alu_in_a      = a_fwd;
    assign alu_in_b      = b_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_rd         = rd_reg;
    assign ex_reg_write  = reg_write_reg && valid_reg;
    assign ex_valid      = valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed check of id_ex_stage against an instruction-level model
// of what EX holds and how its operands resolve against the later pipeline stages.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [3:0]  id_aluop;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic        id_use_imm, id_imm_sign, id_lui, id_use_shamt;
    logic [4:0]  id_shamt;
    logic        id_reg_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_a, alu_in_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
        .id_use_imm(id_use_imm), .id_imm_sign(id_imm_sign), .id_lui(id_lui),
        .id_use_shamt(id_use_shamt), .id_shamt(id_shamt), .id_reg_write(id_reg_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
    );

    // Model of the instruction sitting in EX.
    logic        m_valid, m_rw, m_a_reg, m_b_reg;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs, m_rt;
    logic [31:0] m_a, m_b, m_st;

    function automatic logic [31:0] resolve(input logic [4:0] addr, input logic [31:0] held);
        if (addr == 0) return held;
        if (exm_reg_write && exm_rd == addr) return exm_result;
        if (mwb_reg_write && mwb_rd == addr) return mwb_result;
        return held;
    endfunction

    function automatic logic [31:0] exp_a();
        return m_a_reg ? resolve(m_rs, m_a) : m_a;
    endfunction

    function automatic logic [31:0] exp_b();
        return m_b_reg ? resolve(m_rt, m_b) : m_b;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_a_reg = 0; m_b_reg = 0; m_op = 0;
        m_rd = 0; m_rs = 0; m_rt = 0; m_a = 0; m_b = 0; m_st = 0;
    endtask

    task automatic model_edge();
        logic [31:0] imm;
        if (rst || flush || (!stall && !id_valid)) begin
            model_bubble();
        end else if (stall) begin
            if (m_valid) begin
                m_a  = exp_a();
                m_b  = exp_b();
                m_st = resolve(m_rt, m_st);
            end
        end else begin
            if (id_lui)           imm = {id_imm16, 16'h0000};
            else if (id_imm_sign) imm = $unsigned(32'(signed'(id_imm16)));
            else                  imm = {16'h0000, id_imm16};
            m_valid = 1;
            m_rw    = id_reg_write;
            m_op    = id_lui ? 4'd0 : id_aluop;
            m_rd    = id_rd_addr;
            m_rs    = id_rs_addr;
            m_rt    = id_rt_addr;
            m_a_reg = !id_use_shamt;
            m_b_reg = !(id_use_imm || id_lui);
            m_a     = id_use_shamt ? {27'd0, id_shamt} : id_rs_data;
            m_b     = m_b_reg ? id_rt_data : imm;
            m_st    = id_rt_data;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw & m_valid));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("alu_in_a", alu_in_a, exp_a());
        chk("alu_in_b", alu_in_b, exp_b());
        chk("ex_store_data", ex_store_data, resolve(m_rt, m_st));
        $display("[TB] t=%0t v=%0b op=%h a=%h b=%h st=%h rd=%0d", $time,
                 ex_valid, alu_op, alu_in_a, alu_in_b, ex_store_data, ex_rd);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; id_valid = 0; id_aluop = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm16 = 0; id_use_imm = 0; id_imm_sign = 0; id_lui = 0; id_use_shamt = 0;
        id_shamt = 0; id_reg_write = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    initial begin
        model_bubble();
        idle_inputs();
        rst = 1;
        step();
        step();
        chk("reset valid", 32'(ex_valid), 32'd0);
        chk("reset a", alu_in_a, 32'd0);

        // addi, sign- then zero-extended immediate
        rst = 0; id_valid = 1; id_aluop = 4'b0001; id_rs_addr = 1; id_rs_data = 5;
        id_rt_addr = 2; id_rd_addr = 2; id_imm16 = 16'hFFFF; id_use_imm = 1;
        id_imm_sign = 1; id_reg_write = 1;
        step();
        chk("addi op", 32'(alu_op), 32'd1);
        chk("addi a", alu_in_a, 32'd5);
        chk("addi b sext", alu_in_b, 32'hFFFFFFFF);
        id_imm_sign = 0;
        step();
        chk("addi b zext", alu_in_b, 32'h0000FFFF);

        // reset mid-stream with an add in EX
        id_use_imm = 0; id_rt_data = 9;
        step();
        rst = 1;
        step();
        chk("midrst valid", 32'(ex_valid), 32'd0);
        chk("midrst rw", 32'(ex_reg_write), 32'd0);
        chk("midrst op", 32'(alu_op), 32'd0);
        chk("midrst a", alu_in_a, 32'd0);
        chk("midrst b", alu_in_b, 32'd0);
        rst = 0;

        // lui
        id_lui = 1; id_imm16 = 16'h1234; id_aluop = 4'b0101;
        step();
        chk("lui op", 32'(alu_op), 32'd0);
        chk("lui b", alu_in_b, 32'h12340000);

        // sll: A is shamt, never forwarded; B forwarded from EX/MEM
        id_lui = 0; id_use_shamt = 1; id_shamt = 4; id_aluop = 4'b1000;
        id_rs_addr = 3; id_rs_data = 7; id_rt_addr = 3; id_rt_data = 99;
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'hA;
        step();
        chk("sll a", alu_in_a, 32'd4);
        chk("sll b", alu_in_b, 32'hA);

        // forwarding priority
        id_use_shamt = 0; id_aluop = 4'b0001; id_rs_addr = 7; id_rs_data = 1;
        id_rt_addr = 8; id_rt_data = 2;
        exm_rd = 7; exm_result = 11; mwb_reg_write = 1; mwb_rd = 7; mwb_result = 22;
        step();
        chk("fwd exm", alu_in_a, 32'd11);
        exm_reg_write = 0;
        #1;
        chk("fwd mwb", alu_in_a, 32'd22);
        exm_reg_write = 1; exm_rd = 0; mwb_rd = 0; id_rs_addr = 0; id_rs_data = 32'h55;
        step();
        chk("r0 nofwd", alu_in_a, 32'h55);

        // stall keeps a value forwarded from MEM/WB after the producer moves on
        exm_reg_write = 0; id_rs_addr = 9; id_rs_data = 1; mwb_rd = 9; mwb_result = 33;
        step();
        chk("stall pre", alu_in_a, 32'd33);
        stall = 1;
        step();
        mwb_rd = 4; mwb_result = 44;
        step();
        chk("stall hold1", alu_in_a, 32'd33);
        step();
        chk("stall hold2", alu_in_a, 32'd33);
        flush = 1;
        step();
        chk("flush valid", 32'(ex_valid), 32'd0);

        // randomized traffic on a narrow register range to hit forwarding often
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 49) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            id_valid      = ($urandom_range(0, 7) != 0);
            id_aluop      = 4'($urandom);
            id_rs_addr    = 5'($urandom_range(0, 3));
            id_rt_addr    = 5'($urandom_range(0, 3));
            id_rd_addr    = 5'($urandom);
            id_rs_data    = $urandom;
            id_rt_data    = $urandom;
            id_imm16      = 16'($urandom);
            id_use_imm    = 1'($urandom);
            id_imm_sign   = 1'($urandom);
            id_lui        = ($urandom_range(0, 5) == 0);
            id_use_shamt  = ($urandom_range(0, 4) == 0);
            id_shamt      = 5'($urandom);
            id_reg_write  = 1'($urandom);
            exm_reg_write = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 3));
            exm_result    = $urandom;
            mwb_reg_write = 1'($urandom);
            mwb_rd        = 5'($urandom_range(0, 3));
            mwb_result    = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
